// File: rtl/apb_master_bridge_pkg.sv
// apb_master_bridge_pkg
// Shared definitions for the APB master bridge:
//   - default address/data widths, which match the register slave's macro widths
//   - the bridge state encoding (IDLE=0, SETUP=1, ACCESS=2, RDCAP=3, RESP=4)
//   - a helper that tells whether a state can accept a new command
package apb_master_bridge_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_RDCAP  = 3'd3,
        ST_RESP   = 3'd4
    } state_e;

    // Commands are taken while idle and also in the response cycle, so that
    // back-to-back transfers have no idle gap.
    function automatic logic can_accept(state_e s);
        return (s == ST_IDLE) || (s == ST_RESP);
    endfunction

endpackage

// File: rtl/apb_master_bridge_if.sv
// apb_master_bridge_if
// Bundles the host command/response handshake and the APB bus of the bridge.
//   cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata : host command
//   rsp_valid/rsp_err/rsp_rdata                       : one-cycle response
//   paddr/pwdata/pwrite/psel/penable                  : APB requester outputs
//   prdata (DATA_W+1 wide, msb ignored)/pready         : APB completer inputs
// Modports: master = bridge view, slave = host + APB completer view.
interface apb_master_bridge_if
    import apb_master_bridge_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_err;
    logic [DATA_W-1:0] rsp_rdata;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              pwrite;
    logic              psel;
    logic              penable;
    logic [DATA_W:0]   prdata;
    logic              pready;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready,
        output cmd_ready, rsp_valid, rsp_err, rsp_rdata,
               paddr, pwdata, pwrite, psel, penable
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready,
        input  cmd_ready, rsp_valid, rsp_err, rsp_rdata,
               paddr, pwdata, pwrite, psel, penable
    );
endinterface

// File: rtl/apb_wait_timer.sv
// apb_wait_timer
// Counts APB wait-state cycles and flags when the current ACCESS cycle is the
// last one allowed before the transfer is aborted.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : restart the count (asserted in SETUP, just before ACCESS)
//   count_en   : one more wait cycle elapsed (ACCESS with pready low)
//   expired    : the current ACCESS cycle is the TIMEOUT-th one
module apb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    // cnt holds the number of completed wait cycles, so during the k-th
    // ACCESS cycle it reads k-1; it saturates at LAST.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (count_en && (cnt != LAST)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (cnt == LAST);
endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge
// Turns valid/ready commands into APB SETUP/ACCESS transfers and returns a
// one-cycle response carrying read data or a timeout error. The completer's
// read data is registered, so reads pass through an extra capture state.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : command/response handshake and APB bus (master modport)
module apb_master_bridge
    import apb_master_bridge_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    apb_master_bridge_if.master  bus
);
    state_e            state;
    state_e            next_state;
    logic              accept;
    logic              timeout;
    logic              expired;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              write_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              psel_q;
    logic              penable_q;
    logic              rsp_valid_q;
    logic              unused_prdata_msb;

    assign unused_prdata_msb = bus.prdata[DATA_W];

    assign accept  = can_accept(state) && bus.cmd_valid;
    assign timeout = (state == ST_ACCESS) && !bus.pready && expired;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (state == ST_SETUP),
        .count_en ((state == ST_ACCESS) && !bus.pready),
        .expired  (expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (accept) next_state = ST_SETUP;
            ST_SETUP:  next_state = ST_ACCESS;
            ST_ACCESS: begin
                if (bus.pready) begin
                    next_state = write_q ? ST_RESP : ST_RDCAP;
                end else if (expired) begin
                    next_state = ST_RESP;
                end
            end
            ST_RDCAP:  next_state = ST_RESP;
            ST_RESP:   next_state = accept ? ST_SETUP : ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Bus controls are registered from next_state so they change on the same
    // edge as the state and an asynchronous reset drops them at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            psel_q      <= (next_state == ST_SETUP) || (next_state == ST_ACCESS);
            penable_q   <= (next_state == ST_ACCESS);
            rsp_valid_q <= (next_state == ST_RESP);
            if (accept) begin
                addr_q  <= bus.cmd_addr;
                wdata_q <= bus.cmd_wdata;
                write_q <= bus.cmd_write;
            end
            // Leaving ACCESS: a write or an abort reports zero data; a read
            // overwrites it in RDCAP.
            if ((state == ST_ACCESS) && (next_state != ST_ACCESS)) begin
                err_q   <= timeout;
                rdata_q <= '0;
            end
            if (state == ST_RDCAP) begin
                rdata_q <= bus.prdata[DATA_W-1:0];
            end
        end
    end

    assign bus.cmd_ready = can_accept(state) && !reset;
    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_valid_q && err_q;
    assign bus.rsp_rdata = rsp_valid_q ? rdata_q : '0;
    assign bus.paddr     = addr_q;
    assign bus.pwdata    = wdata_q;
    assign bus.pwrite    = write_q;
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge
// Directed bench for apb_master_bridge with a registered-read APB register
// model. Cycle numbers count from the command accept edge (cycle 1 = SETUP).
module tb_apb_master_bridge;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;
    logic [7:0] mem [0:255];

    apb_master_bridge_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    apb_master_bridge #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register completer: writes at the ACCESS edge, read data appears one
    // cycle after the ACCESS edge with the unused msb forced high.
    always @(posedge clk) begin
        if (bus.psel && bus.penable && bus.pready) begin
            if (bus.pwrite) mem[bus.paddr] <= bus.pwdata;
            else            bus.prdata <= {1'b1, mem[bus.paddr]};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one command and follows it until its response (bounded).
    // pready is held low for the first 'waits' ACCESS cycles.
    task automatic run_cmd(input logic w, input logic [7:0] a, input logic [7:0] d,
                           input int waits, output int rsp_cyc, output logic err,
                           output logic [7:0] rd, output int psel_n, output int pen_n,
                           output logic bad_en, output logic psel_at_rsp);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        bus.pready    = 1'b1;
        step();
        bus.cmd_valid = 1'b0;
        rsp_cyc = -1; err = 1'b0; rd = '0; psel_n = 0; pen_n = 0;
        bad_en = 1'b0; psel_at_rsp = 1'b0;
        for (int c = 1; c <= 40 && rsp_cyc < 0; c++) begin
            if (bus.psel) psel_n++;
            if (bus.penable) pen_n++;
            if (bus.penable && !bus.psel) bad_en = 1'b1;
            if (bus.rsp_valid) begin
                rsp_cyc = c; err = bus.rsp_err; rd = bus.rsp_rdata; psel_at_rsp = bus.psel;
            end
            bus.pready = !(bus.penable && pen_n <= waits);
            step();
        end
        bus.pready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_cmp++;
        if ({bus.psel, bus.penable, bus.rsp_valid, bus.rsp_err, bus.pwrite} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {bus.psel, bus.penable, bus.rsp_valid, bus.rsp_err, bus.pwrite});
        end
        n_cmp++;
        if ({bus.paddr, bus.pwdata, bus.rsp_rdata} !== 24'h0) begin
            n_bad++;
            $display("FAIL reset_data: got %h expected 000000", {bus.paddr, bus.pwdata, bus.rsp_rdata});
        end
        n_cmp++;
        if (bus.cmd_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ready_low: got %b expected 0", bus.cmd_ready);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (bus.cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready_high: got %b expected 1", bus.cmd_ready);
        end
        step();
    endtask

    task automatic test_write();
        int rc, pn, en; logic er, be, pr; logic [7:0] rd;
        run_cmd(1'b1, 8'd3, 8'h5A, 0, rc, er, rd, pn, en, be, pr);
        n_cmp++;
        if ({rc, pn, en} !== {32'd3, 32'd2, 32'd1}) begin
            n_bad++;
            $display("FAIL write_timing: got rsp=%0d psel=%0d pen=%0d expected rsp=3 psel=2 pen=1", rc, pn, en);
        end
        n_cmp++;
        if ({er, rd, be} !== 10'b0) begin
            n_bad++;
            $display("FAIL write_rsp: got err=%b rdata=%h bad_en=%b expected 0 00 0", er, rd, be);
        end
        n_cmp++;
        if ({mem[3], bus.paddr, bus.pwrite} !== {8'h5A, 8'd3, 1'b1}) begin
            n_bad++;
            $display("FAIL write_mem: got mem=%h paddr=%h pwrite=%b expected 5a 03 1",
                     mem[3], bus.paddr, bus.pwrite);
        end
    endtask

    task automatic test_read();
        int rc, pn, en; logic er, be, pr; logic [7:0] rd;
        run_cmd(1'b0, 8'd3, 8'h00, 0, rc, er, rd, pn, en, be, pr);
        n_cmp++;
        if ({rc, pn, en} !== {32'd4, 32'd2, 32'd1}) begin
            n_bad++;
            $display("FAIL read_timing: got rsp=%0d psel=%0d pen=%0d expected rsp=4 psel=2 pen=1", rc, pn, en);
        end
        n_cmp++;
        if ({er, rd} !== {1'b0, 8'h5A}) begin
            n_bad++;
            $display("FAIL read_data: got err=%b rdata=%h expected 0 5a", er, rd);
        end
    endtask

    task automatic test_wait_states();
        int rc, pn, en; logic er, be, pr; logic [7:0] rd;
        run_cmd(1'b1, 8'd5, 8'hC3, 3, rc, er, rd, pn, en, be, pr);
        n_cmp++;
        if ({rc, en, pn} !== {32'd6, 32'd4, 32'd5}) begin
            n_bad++;
            $display("FAIL wait_timing: got rsp=%0d pen=%0d psel=%0d expected rsp=6 pen=4 psel=5", rc, en, pn);
        end
        n_cmp++;
        if ({er, mem[5]} !== {1'b0, 8'hC3}) begin
            n_bad++;
            $display("FAIL wait_write: got err=%b mem=%h expected 0 c3", er, mem[5]);
        end
    endtask

    task automatic test_timeout();
        int rc, pn, en; logic er, be, pr; logic [7:0] rd;
        run_cmd(1'b0, 8'd3, 8'h00, 1000, rc, er, rd, pn, en, be, pr);
        n_cmp++;
        if ({rc, en, pn} !== {32'd18, 32'd16, 32'd17}) begin
            n_bad++;
            $display("FAIL timeout_timing: got rsp=%0d pen=%0d psel=%0d expected rsp=18 pen=16 psel=17", rc, en, pn);
        end
        n_cmp++;
        if ({er, rd, pr, be} !== {1'b1, 8'h00, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL timeout_rsp: got err=%b rdata=%h psel=%b bad_en=%b expected 1 00 0 0", er, rd, pr, be);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] seen [1:6];
        bus.pready    = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 8'd0;
        bus.cmd_wdata = 8'h01;
        step();
        bus.cmd_addr  = 8'd1;
        for (int c = 1; c <= 6; c++) begin
            seen[c] = {bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready, bus.paddr[1:0]};
            if (c == 4) bus.cmd_valid = 1'b0;
            step();
        end
        n_cmp++;
        if ({seen[1], seen[2], seen[3]} !== {6'b100000, 6'b110000, 6'b001100}) begin
            n_bad++;
            $display("FAIL b2b_first: got %b %b %b expected 100000 110000 001100", seen[1], seen[2], seen[3]);
        end
        n_cmp++;
        if ({seen[4], seen[5], seen[6]} !== {6'b100001, 6'b110001, 6'b001101}) begin
            n_bad++;
            $display("FAIL b2b_second: got %b %b %b expected 100001 110001 001101", seen[4], seen[5], seen[6]);
        end
        n_cmp++;
        if ({mem[0], mem[1]} !== 16'h0101) begin
            n_bad++;
            $display("FAIL b2b_mem: got %h %h expected 01 01", mem[0], mem[1]);
        end
    endtask

    task automatic test_reset_mid_access();
        int stray;
        bus.pready    = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 8'd3;
        step();
        bus.cmd_valid = 1'b0;
        step();
        n_cmp++;
        if ({bus.psel, bus.penable} !== 2'b11) begin
            n_bad++;
            $display("FAIL midrst_access: got %b expected 11", {bus.psel, bus.penable});
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready} !== 4'b0000) begin
            n_bad++;
            $display("FAIL midrst_async: got %b expected 0000",
                     {bus.psel, bus.penable, bus.rsp_valid, bus.cmd_ready});
        end
        step();
        reset = 1'b0;
        bus.pready = 1'b1;
        #1;
        n_cmp++;
        if (bus.cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_ready: got %b expected 1", bus.cmd_ready);
        end
        stray = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (bus.rsp_valid || bus.psel) stray++;
        end
        n_cmp++;
        if (stray !== 0) begin
            n_bad++;
            $display("FAIL midrst_dropped: got %0d stray cycles expected 0", stray);
        end
    endtask

    task automatic test_read_after_reset();
        int rc, pn, en; logic er, be, pr; logic [7:0] rd;
        run_cmd(1'b0, 8'd1, 8'h00, 0, rc, er, rd, pn, en, be, pr);
        n_cmp++;
        if ({rc, er, rd} !== {32'd4, 1'b0, 8'h01}) begin
            n_bad++;
            $display("FAIL read_after_reset: got rsp=%0d err=%b rdata=%h expected 4 0 01", rc, er, rd);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.pready    = 1'b1;
        bus.prdata    = '0;
        test_reset();
        test_write();
        test_read();
        test_wait_states();
        test_timeout();
        test_back_to_back();
        test_reset_mid_access();
        test_read_after_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
